bus_master: RTL and testbench

- Command-driven master that sits directly upstream of the 4-entry register slave.
- Accepts read/write requests on a valid/ready request port and buffers them in a small command FIFO.
- Issues each request as a one-cycle rd or wr strobe on the slave's bus pins, captures read data one cycle later, and returns one in-order response per request on a valid/ready response port.

---
 rtl/bus_master.sv | 170 +++++++++++++++++
 tb/tb_bus_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// bus_master: buffers read/write commands in a small FIFO and runs them one at a time
// against the 4-entry register slave. Define BUS_MASTER_STATS_EN for completion counters.
module bus_master #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [EntW-1:0]   fifo_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              full, empty, push, pop;

    assign full      = (cnt_q == CntW'(DEPTH));
    assign empty     = (cnt_q == '0);
    // No bypass when full: a pop in the same cycle does not open a slot until the next one.
    assign req_ready = rstn & ~full;
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == StIdle) & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    {write_d, addr_d, wdata_d} = fifo_q[rptr_q];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (write_q) begin
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    state_d = StCapture;
                end
            end
            // Slave dout was updated at the ISSUE edge; capture it at the end of this cycle.
            StCapture: begin
                rdata_d = bus_rdata;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_rd    = (state_q == StIssue) & ~write_q;
    assign bus_wr    = (state_q == StIssue) & write_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign rsp_valid = (state_q == StResp);
    assign rsp_write = write_q;
    assign rsp_addr  = addr_q;
    assign rsp_rdata = rdata_q;

    assign busy = ~empty | (state_q != StIdle);

`ifdef BUS_MASTER_STATS_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;
    logic        rsp_done;

    assign rsp_done = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (rsp_done) begin
            if (write_q && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (!write_q && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign stat_wr_cnt = wr_cnt_q;
    assign stat_rd_cnt = rd_cnt_q;
`else
    assign stat_wr_cnt = '0;
    assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master with a behavioural 4-register slave and an
// in-order response scoreboard.
module tb_bus_master;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [1:0]  rsp_addr;
    logic [31:0] rsp_rdata;
    logic        bus_rd, bus_wr;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        busy;
    logic [15:0] stat_wr_cnt, stat_rd_cnt;

    typedef struct packed {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        got, exp_e;
    logic [31:0] shadow [4];
    logic [31:0] slv_regs [4];

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_seen = 0;
    int rd_strobes = 0;
    int wr_strobes = 0;

    bus_master #(.ADDR_W(2), .DATA_W(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_addr    (rsp_addr),
        .rsp_rdata   (rsp_rdata),
        .bus_rd      (bus_rd),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .busy        (busy),
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave: write on wr, dout loads on rd.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) slv_regs[i] <= '0;
            bus_rdata <= '0;
        end else begin
            if (bus_wr) slv_regs[bus_addr] <= bus_wdata;
            if (bus_rd) bus_rdata <= slv_regs[bus_addr];
        end
    end

    // Response monitor / scoreboard pop.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus_rd) rd_strobes++;
            if (bus_wr) wr_strobes++;
            if (bus_rd && bus_wr) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_overlap: rd=%0b wr=%0b, required not both high", bus_rd, bus_wr);
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                rsp_seen++;
                got = {rsp_write, rsp_addr, rsp_rdata};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: got w=%0b a=%0d d=%h, required no response",
                             got.w, got.a, got.d);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (got !== exp_e) begin
                        n_fail++;
                        $display("FAIL rsp_order: got w=%0b a=%0d d=%h, required w=%0b a=%0d d=%h",
                                 got.w, got.a, got.d, exp_e.w, exp_e.a, exp_e.d);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call at #1 after a posedge; returns #1 after the handshake edge.
    task automatic push_req(input logic w, input logic [1:0] a, input logic [31:0] d);
        int   guard = 0;
        rsp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL push_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, guard);
        end
        if (w) begin
            shadow[a] = d;
            e = {1'b1, a, 32'h0};
        end else begin
            e = {1'b0, a, shadow[a]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d busy=%0b, required 0 and 0", exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        #3;
        n_checks++;
        if ({bus_rd, bus_wr, rsp_valid, busy, req_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd/wr/rv/busy/rdy=%b, required 00000",
                     {bus_rd, bus_wr, rsp_valid, busy, req_ready});
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%0b busy=%0b rv=%0b, required 1 0 0",
                     req_ready, busy, rsp_valid);
        end
        n_checks++;
        if ({bus_addr, bus_wdata, rsp_rdata, stat_wr_cnt, stat_rd_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d wdata=%h rdata=%h, required all 0",
                     bus_addr, bus_wdata, rsp_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        push_req(1'b1, 2'd2, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if (bus_wr !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_n1: bus_wr=%0b busy=%0b, required 0 1", bus_wr, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({bus_wr, bus_rd, bus_addr, bus_wdata} !== {1'b1, 1'b0, 2'd2, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL wr_n2: wr=%0b rd=%0b addr=%0d din=%h, required 1 0 2 deadbeef",
                     bus_wr, bus_rd, bus_addr, bus_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_n3: rv=%0b rw=%0b rdata=%h, required 1 1 0", rsp_valid, rsp_write, rsp_rdata);
        end
        wait_drain();

        push_req(1'b0, 2'd2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_rd !== 1'b1 || bus_wr !== 1'b0 || bus_addr !== 2'd2) begin
            n_fail++;
            $display("FAIL rd_n2: rd=%0b wr=%0b addr=%0d, required 1 0 2", bus_rd, bus_wr, bus_addr);
        end
        @(negedge clk);
        n_checks++;
        if (bus_rd !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_n3: rd=%0b rv=%0b, required 0 0", bus_rd, rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_n4: rv=%0b rw=%0b rdata=%h, required 1 0 deadbeef",
                     rsp_valid, rsp_write, rsp_rdata);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] wv [4];
        int          rd0, wr0, rs0;
        wv[0] = 32'h11; wv[1] = 32'h22; wv[2] = 32'h33; wv[3] = 32'h44;
        rd0 = rd_strobes; wr0 = wr_strobes; rs0 = rsp_seen;
        for (int i = 0; i < 4; i++) push_req(1'b1, 2'(i), wv[i]);
        push_req(1'b0, 2'd3, 32'h0);
        push_req(1'b0, 2'd0, 32'h0);
        push_req(1'b0, 2'd1, 32'h0);
        push_req(1'b0, 2'd2, 32'h0);
        wait_drain();
        n_checks++;
        if (wr_strobes - wr0 != 4 || rd_strobes - rd0 != 4 || rsp_seen - rs0 != 8) begin
            n_fail++;
            $display("FAIL b2b_counts: wr=%0d rd=%0d rsp=%0d, required 4 4 8",
                     wr_strobes - wr0, rd_strobes - rd0, rsp_seen - rs0);
        end
    endtask

    task automatic test_backpressure();
        int rs0;
        rs0 = rsp_seen;
        rsp_ready = 1'b0;
        push_req(1'b1, 2'd0, 32'hA0);
        push_req(1'b0, 2'd0, 32'h0);
        push_req(1'b1, 2'd1, 32'hB1);
        push_req(1'b0, 2'd1, 32'h0);
        push_req(1'b0, 2'd3, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 2'd0 || rsp_write !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: rdy=%0b rv=%0b addr=%0d rw=%0b, required 0 1 0 1",
                     req_ready, rsp_valid, rsp_addr, rsp_write);
        end
        @(posedge clk);
        #1;
        fork
            push_req(1'b1, 2'd2, 32'hC2);
            begin
                repeat (3) @(negedge clk);
                n_checks++;
                if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stall: rdy=%0b rv=%0b, required 0 1", req_ready, rsp_valid);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (rsp_seen - rs0 != 6) begin
            n_fail++;
            $display("FAIL bp_drain: responses=%0d, required 6", rsp_seen - rs0);
        end
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        push_req(1'b0, 2'd2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_issue: bus_rd=%0b, required 1", bus_rd);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus_rd, bus_wr, rsp_valid, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_drop: rd/wr/rv/busy=%b, required 0000", {bus_rd, bus_wr, rsp_valid, busy});
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_after: rdy=%0b busy=%0b wr=%0d rd=%0d, required 1 0 0 0",
                     req_ready, busy, stat_wr_cnt, stat_rd_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) hi++;
        end
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL rst_stale: rsp_valid high %0d cycles, required 0", hi);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stats();
        logic [15:0] exp_wr, exp_rd;
`ifdef BUS_MASTER_STATS_EN
        exp_wr = 16'd3;
        exp_rd = 16'd2;
`else
        exp_wr = 16'd0;
        exp_rd = 16'd0;
`endif
        push_req(1'b1, 2'd0, 32'h5);
        push_req(1'b0, 2'd0, 32'h0);
        push_req(1'b1, 2'd1, 32'h6);
        push_req(1'b1, 2'd3, 32'h7);
        push_req(1'b0, 2'd3, 32'h0);
        wait_drain();
        @(negedge clk);
        n_checks++;
        if (stat_wr_cnt !== exp_wr || stat_rd_cnt !== exp_rd) begin
            n_fail++;
            $display("FAIL stats: wr=%0d rd=%0d, required %0d %0d",
                     stat_wr_cnt, stat_rd_cnt, exp_wr, exp_rd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
